bus_register: RTL and testbench

//   Single-clock, DATA_WIDTH-bit storage register for a shared tri-state data bus.
//   - Captures its input on a clock edge when load is asserted.
//   - Drives the stored value onto its output only while output-enable is high, otherwise high-Z.
//   - The input and output may be tied to the same bidirectional bus net, so the block is a general-purpose bus register.

---
 rtl/bus_register_if.sv | 11 +
 rtl/bus_register.sv | 25 ++
 tb/tb_bus_register.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_register_if.sv
// rtl/bus_register_if.sv - control and capture-side signals of the bus register
interface bus_register_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  notLoad;
   logic                  OE;
   logic [DATA_WIDTH-1:0] in;

   modport master (output notLoad, OE, in);
   modport slave  (input  notLoad, OE, in);
endinterface

// File: rtl/bus_register.sv
// rtl/bus_register.sv - DATA_WIDTH-bit register with load enable and tri-state output
// Input and output may share one bus net; reset is required before the stored word is meaningful.
module bus_register #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  notReset,
   bus_register_if.slave         bus,
   output wire  [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] q;

   // Reset dominates load; X/Z on the input is captured unaltered.
   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         q <= '0;
      end else if (!bus.notLoad) begin
         q <= bus.in;
      end
   end

   assign out = bus.OE ? q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_register.sv
// tb/tb_bus_register.sv - self-checking bench for bus_register on a shared bus net
module tb_bus_register;

   localparam int W = 16;

   logic         clock;
   logic         notReset;
   logic         oe_tb;
   logic [W-1:0] drv;
   wire  [W-1:0] bus;

   int compared;
   int mismatched;
   logic [W-1:0] model_q;

   bus_register_if #(.DATA_WIDTH(W)) bif ();

   assign bus     = oe_tb ? drv : {W{1'bz}};
   assign bif.in  = bus;

   bus_register #(.DATA_WIDTH(W)) dut (
      .clock    (clock),
      .notReset (notReset),
      .bus      (bif.slave),
      .out      (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic test_reset();
      notReset    = 1'b1;
      oe_tb       = 1'b0;
      drv         = '0;
      bif.OE      = 1'b0;
      bif.notLoad = 1'b1;
      #3;
      notReset = 1'b0;
      #20;
      notReset = 1'b1;
      model_q  = '0;
      @(negedge clock);
      bif.OE = 1'b1;
      #1;
      compared++;
      if (bus !== 16'h0000) begin
         mismatched++;
         $display("FAIL reset_value: got %h expected %h", bus, 16'h0000);
      end
   endtask

   task automatic test_output_disable();
      logic [W-1:0] v;
      v = W'($urandom);
      @(negedge clock);
      bif.OE = 1'b0;
      oe_tb  = 1'b1;
      drv    = v;
      #1;
      compared++;
      if (bus !== v) begin
         mismatched++;
         $display("FAIL oe_off_released: got %h expected %h", bus, v);
      end
      bif.notLoad = 1'b0;
      #1;
      bif.notLoad = 1'b1;
      #1;
      oe_tb  = 1'b0;
      bif.OE = 1'b1;
      #1;
      compared++;
      if (bus !== model_q) begin
         mismatched++;
         $display("FAIL notload_no_edge: got %h expected %h", bus, model_q);
      end
   endtask

   task automatic load_word(input logic [W-1:0] v);
      @(negedge clock);
      bif.OE      = 1'b0;
      oe_tb       = 1'b1;
      drv         = v;
      bif.notLoad = 1'b0;
      @(posedge clock);
      model_q = v;
      @(negedge clock);
      bif.notLoad = 1'b1;
      oe_tb       = 1'b0;
      bif.OE      = 1'b1;
   endtask

   task automatic test_load();
      load_word(16'hF0F0);
      #1;
      compared++;
      if (bus !== 16'hF0F0) begin
         mismatched++;
         $display("FAIL load_f0f0: got %h expected %h", bus, 16'hF0F0);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         compared++;
         if (bus !== 16'hF0F0) begin
            mismatched++;
            $display("FAIL hold_f0f0 edge %0d: got %h expected %h", i, bus, 16'hF0F0);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      #2;
      notReset = 1'b0;
      model_q  = '0;
      #1;
      compared++;
      if (bus !== 16'h0000) begin
         mismatched++;
         $display("FAIL async_clear: got %h expected %h", bus, 16'h0000);
      end
      @(negedge clock);
      notReset = 1'b1;
   endtask

   task automatic test_reset_priority();
      load_word(16'hF0F0);
      @(negedge clock);
      bif.OE      = 1'b0;
      oe_tb       = 1'b1;
      drv         = 16'h5A5A;
      bif.notLoad = 1'b0;
      notReset    = 1'b0;
      model_q     = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      bif.notLoad = 1'b1;
      notReset    = 1'b1;
      oe_tb       = 1'b0;
      bif.OE      = 1'b1;
      #1;
      compared++;
      if (bus !== 16'h0000) begin
         mismatched++;
         $display("FAIL reset_beats_load: got %h expected %h", bus, 16'h0000);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      bif.OE      = 1'b0;
      oe_tb       = 1'b1;
      drv         = 16'h1234;
      bif.notLoad = 1'b0;
      @(posedge clock);
      #1;
      oe_tb  = 1'b0;
      bif.OE = 1'b1;
      #1;
      compared++;
      if (bus !== 16'h1234) begin
         mismatched++;
         $display("FAIL b2b_first: got %h expected %h", bus, 16'h1234);
      end
      @(negedge clock);
      #1;
      compared++;
      if (bus !== 16'h1234) begin
         mismatched++;
         $display("FAIL b2b_first_falling: got %h expected %h", bus, 16'h1234);
      end
      bif.OE = 1'b0;
      oe_tb  = 1'b1;
      drv    = 16'hABCD;
      @(posedge clock);
      #1;
      oe_tb  = 1'b0;
      bif.OE = 1'b1;
      #1;
      compared++;
      if (bus !== 16'hABCD) begin
         mismatched++;
         $display("FAIL b2b_second: got %h expected %h", bus, 16'hABCD);
      end
      @(negedge clock);
      bif.notLoad = 1'b1;
      #1;
      compared++;
      if (bus !== 16'hABCD) begin
         mismatched++;
         $display("FAIL b2b_second_falling: got %h expected %h", bus, 16'hABCD);
      end
      model_q = 16'hABCD;
   endtask

   // Each cycle picks one of: external load, self-load on the shared bus, hold with
   // bus released or driven by the bench, optionally with reset asserted.
   task automatic test_random();
      int mode;
      logic rst;
      logic [W-1:0] v;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         notReset = 1'b1;
         mode = int'($urandom_range(0, 3));
         rst  = ($urandom_range(0, 9) == 0);
         v    = W'($urandom);
         drv  = v;
         case (mode)
            0: begin bif.OE = 1'b0; oe_tb = 1'b1; bif.notLoad = 1'b0; end
            1: begin bif.OE = 1'b1; oe_tb = 1'b0; bif.notLoad = 1'b0; end
            2: begin bif.OE = 1'b1; oe_tb = 1'b0; bif.notLoad = 1'b1; end
            default: begin bif.OE = 1'b0; oe_tb = 1'b1; bif.notLoad = 1'b1; end
         endcase
         if (rst) begin
            #1;
            notReset = 1'b0;
            model_q  = '0;
            #1;
            if (bif.OE) begin
               compared++;
               if (bus !== 16'h0000) begin
                  mismatched++;
                  $display("FAIL rand_async_reset %0d: got %h expected %h", i, bus, 16'h0000);
               end
            end
         end
         @(posedge clock);
         if (!rst && mode == 0) model_q = v;
         #1;
         compared++;
         if (bif.OE) begin
            if (bus !== model_q) begin
               mismatched++;
               $display("FAIL rand_out %0d mode %0d: got %h expected %h", i, mode, bus, model_q);
            end
         end else begin
            if (bus !== v) begin
               mismatched++;
               $display("FAIL rand_released %0d: got %h expected %h", i, bus, v);
            end
         end
      end
      @(negedge clock);
      notReset    = 1'b1;
      bif.notLoad = 1'b1;
      oe_tb       = 1'b0;
      bif.OE      = 1'b1;
      #1;
      compared++;
      if (bus !== model_q) begin
         mismatched++;
         $display("FAIL rand_final: got %h expected %h", bus, model_q);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      model_q    = '0;
      test_reset();
      test_output_disable();
      test_load();
      test_async_reset();
      test_reset_priority();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
